// File: rtl/fe_capture_sequencer.sv
// fe_capture_sequencer: turns sampled UTMI receive activity into DATA/STAT/TIME sniff-FIFO words
// with delta timestamps, using a one-word hold register when a TIME word must go first.
module fe_capture_sequencer #(
    parameter int pTIME_SHORT_LEN = 3,
    parameter int pTIME_FULL_LEN  = 16
) (
    input  logic        fe_clk,
    input  logic        reset,
    input  logic        capture_en,
    input  logic        timestamps_en,
    input  logic [7:0]  fe_data,
    input  logic        fe_rxvalid,
    input  logic        fe_rxactive,
    input  logic        fe_rxerror,
    input  logic        fe_sessvld,
    input  logic        fe_sessend,
    input  logic        fe_vbusvld,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [17:0] fifo_din,
    output logic        overflow,
    output logic [15:0] data_count
);
    localparam int T = pTIME_FULL_LEN;
    localparam int SHORT_MAX = (1 << pTIME_SHORT_LEN) - 1;

    logic [T-1:0] tcount_q, tcount_d;
    logic         armed_q, armed_d;
    logic         cap_q;
    logic         hold_vld_q, hold_vld_d;
    logic [17:0]  hold_q, hold_d;
    logic         stat_pend_q, stat_pend_d;
    logic [4:0]   snap_q, snap_d;
    logic         fifo_wr_q, fifo_wr_d;
    logic [17:0]  fifo_din_q, fifo_din_d;
    logic         overflow_q, overflow_d;
    logic [15:0]  data_count_q, data_count_d, cnt_base;

    logic [4:0]   status;
    logic         cap_rise, data_ev, stat_ev, ev, long_gap, wrap, wr_req;
    logic [2:0]   short_t;
    logic [17:0]  ev_word, time_word, word;

    assign status    = {fe_vbusvld, fe_sessend, fe_sessvld, fe_rxerror, fe_rxactive};
    assign cap_rise  = capture_en & ~cap_q;
    assign data_ev   = capture_en & fe_rxvalid;
    // STAT waits behind the hold register and behind any byte on the same cycle
    assign stat_ev   = capture_en & stat_pend_q & ~hold_vld_q & ~fe_rxvalid;
    assign ev        = data_ev | stat_ev;
    assign long_gap  = timestamps_en & (tcount_q > T'(SHORT_MAX));
    assign short_t   = (timestamps_en & ~long_gap) ? 3'(tcount_q) : 3'd0;
    assign wrap      = timestamps_en & ~hold_vld_q & ~ev & (&tcount_q);
    assign ev_word   = data_ev ? {2'b00, fe_data, 5'd0, short_t} : {2'b01, 8'd0, status, short_t};
    assign time_word = {2'b10, 16'(tcount_q)};
    assign wr_req    = hold_vld_q | ev | wrap;
    assign word      = hold_vld_q ? hold_q : (ev & ~long_gap) ? ev_word : time_word;

    assign hold_vld_d  = hold_vld_q ? data_ev : (ev & long_gap);
    assign hold_d      = (hold_vld_q ? data_ev : (ev & long_gap)) ? ev_word : hold_q;
    // The wrap cycle itself is the first idle cycle of the next TIME span, hence restart at 1
    assign tcount_d    = (~capture_en | ~timestamps_en | ev) ? '0
                       : wrap    ? T'(1)
                       : armed_q ? tcount_q + T'(1) : tcount_q;
    assign armed_d     = capture_en & (armed_q | ev);
    assign stat_pend_d = capture_en & ~stat_ev & (stat_pend_q | (~cap_rise & (status != snap_q)));
    assign snap_d      = (cap_rise | stat_ev) ? status : snap_q;

    assign fifo_wr_d    = wr_req & ~fifo_full;
    assign fifo_din_d   = fifo_wr_d ? word : fifo_din_q;
    assign overflow_d   = (overflow_q & ~cap_rise) | (wr_req & fifo_full);
    assign cnt_base     = cap_rise ? 16'd0 : data_count_q;
    assign data_count_d = (fifo_wr_d & (word[17:16] == 2'b00) & ~(&cnt_base)) ? cnt_base + 16'd1 : cnt_base;

    always_ff @(posedge fe_clk) begin
        if (reset) begin
            tcount_q     <= '0;
            armed_q      <= 1'b0;
            cap_q        <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_q       <= '0;
            stat_pend_q  <= 1'b0;
            snap_q       <= '0;
            fifo_wr_q    <= 1'b0;
            fifo_din_q   <= '0;
            overflow_q   <= 1'b0;
            data_count_q <= '0;
        end else begin
            tcount_q     <= tcount_d;
            armed_q      <= armed_d;
            cap_q        <= capture_en;
            hold_vld_q   <= hold_vld_d;
            hold_q       <= hold_d;
            stat_pend_q  <= stat_pend_d;
            snap_q       <= snap_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_din_q   <= fifo_din_d;
            overflow_q   <= overflow_d;
            data_count_q <= data_count_d;
        end
    end

    assign fifo_wr    = fifo_wr_q;
    assign fifo_din   = fifo_din_q;
    assign overflow   = overflow_q;
    assign data_count = data_count_q;
endmodule

// File: tb/tb_fe_capture_sequencer.sv
// tb_fe_capture_sequencer: per-cycle vector table plus queued-word sequences for long gaps,
// coincident STAT, wrap-around TIME words and mid-operation reset.
module tb_fe_capture_sequencer;
    logic        fe_clk = 1'b0;
    logic        reset = 1'b1;
    logic        capture_en = 1'b0;
    logic        timestamps_en = 1'b0;
    logic [7:0]  fe_data = 8'd0;
    logic        fe_rxvalid = 1'b0;
    logic [4:0]  st = 5'd0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [17:0] fifo_din;
    logic        overflow;
    logic [15:0] data_count;

    fe_capture_sequencer dut (
        .fe_clk(fe_clk), .reset(reset), .capture_en(capture_en), .timestamps_en(timestamps_en),
        .fe_data(fe_data), .fe_rxvalid(fe_rxvalid),
        .fe_rxactive(st[0]), .fe_rxerror(st[1]), .fe_sessvld(st[2]), .fe_sessend(st[3]), .fe_vbusvld(st[4]),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .overflow(overflow), .data_count(data_count)
    );

    always #5 fe_clk = ~fe_clk;

    typedef struct {
        logic        rst, cap, ts, rxv, full;
        logic [7:0]  data;
        logic [4:0]  st;
        logic        ewr, eovf;
        logic [17:0] edin;
        logic [15:0] ecnt;
    } vec_t;

    vec_t        tbl[$];
    logic [17:0] wq[$];
    logic [17:0] eq[$];
    int          nvec = 0;
    int          nmis = 0;

    always @(negedge fe_clk) if (fifo_wr) wq.push_back(fifo_din);

    function automatic vec_t mk(logic rst, cap, ts, rxv, logic [7:0] d, logic [4:0] s, logic full,
                                logic ewr, logic [17:0] edin, logic eovf, logic [15:0] ecnt);
        vec_t v;
        v.rst = rst; v.cap = cap; v.ts = ts; v.rxv = rxv; v.data = d; v.st = s; v.full = full;
        v.ewr = ewr; v.edin = edin; v.eovf = eovf; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic cyc(logic cap, ts, rxv, logic [7:0] d, logic [4:0] s);
        reset = 1'b0; fifo_full = 1'b0;
        capture_en = cap; timestamps_en = ts; fe_rxvalid = rxv; fe_data = d; st = s;
        @(posedge fe_clk); #1;
    endtask

    task automatic idle(int n, logic ts, logic [4:0] s);
        for (int i = 0; i < n; i++) cyc(1'b1, ts, 1'b0, 8'h00, s);
    endtask

    task automatic cmp_q(string n);
        chk({n, "_len"}, wq.size(), eq.size());
        for (int i = 0; i < eq.size(); i++)
            if (i < wq.size()) chk($sformatf("%s_w%0d", n, i), 32'(wq[i]), 32'(eq[i]));
    endtask

    initial begin
        tbl.push_back(mk(1,0,0,0,8'h00,5'd0,0, 0,18'h0,0,16'd0));
        tbl.push_back(mk(1,1,1,1,8'hFF,5'd0,0, 0,18'h0,0,16'd0));
        tbl.push_back(mk(0,1,1,1,8'hA5,5'd0,0, 1,18'h0A500,0,16'd1));
        tbl.push_back(mk(0,1,1,1,8'h3C,5'd0,0, 1,18'h03C00,0,16'd2));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,1,0,8'h00,5'd0,0, 0,18'h0,0,16'd2));
        tbl.push_back(mk(0,1,1,1,8'h7E,5'd0,0, 1,18'h07E05,0,16'd3));
        tbl.push_back(mk(0,1,1,1,8'h11,5'd0,1, 0,18'h0,1,16'd3));
        tbl.push_back(mk(0,1,1,1,8'h12,5'd0,1, 0,18'h0,1,16'd3));
        tbl.push_back(mk(0,1,1,1,8'h13,5'd0,1, 0,18'h0,1,16'd3));
        tbl.push_back(mk(0,1,1,1,8'h14,5'd0,0, 1,18'h01400,1,16'd4));
        tbl.push_back(mk(0,0,1,0,8'h00,5'd0,0, 0,18'h0,1,16'd4));
        tbl.push_back(mk(0,1,1,0,8'h00,5'd0,0, 0,18'h0,0,16'd0));
        tbl.push_back(mk(0,1,1,0,8'h00,5'd0,0, 0,18'h0,0,16'd0));
        tbl.push_back(mk(0,1,1,1,8'h20,5'd0,0, 1,18'h02000,0,16'd1));
        for (int i = 0; i < 30; i++) tbl.push_back(mk(0,1,0,0,8'h00,5'd0,0, 0,18'h0,0,16'd1));
        tbl.push_back(mk(0,1,0,1,8'h21,5'd0,0, 1,18'h02100,0,16'd2));
        tbl.push_back(mk(0,1,0,1,8'h22,5'd0,0, 1,18'h02200,0,16'd3));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0,1,1,0,8'h00,5'd0,0, 0,18'h0,0,16'd3));
        tbl.push_back(mk(0,1,1,0,8'h00,5'b00100,0, 0,18'h0,0,16'd3));
        tbl.push_back(mk(0,1,1,0,8'h00,5'b00100,0, 1,18'h2000B,0,16'd3));
        tbl.push_back(mk(0,1,1,0,8'h00,5'b00100,0, 1,18'h10020,0,16'd3));
        tbl.push_back(mk(0,1,1,0,8'h00,5'b00100,0, 0,18'h0,0,16'd3));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; capture_en = tbl[i].cap; timestamps_en = tbl[i].ts;
            fe_rxvalid = tbl[i].rxv; fe_data = tbl[i].data; st = tbl[i].st; fifo_full = tbl[i].full;
            @(posedge fe_clk); #1;
            chk($sformatf("v%0d_wr", i), 32'(fifo_wr), 32'(tbl[i].ewr));
            if (tbl[i].ewr) chk($sformatf("v%0d_din", i), 32'(fifo_din), 32'(tbl[i].edin));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].eovf));
            chk($sformatf("v%0d_cnt", i), 32'(data_count), 32'(tbl[i].ecnt));
        end

        wq.delete();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 5'b00100);
        cyc(1'b1, 1'b1, 1'b1, 8'h11, 5'b00100);
        idle(20, 1'b1, 5'b00100);
        cyc(1'b1, 1'b1, 1'b1, 8'h22, 5'b00100);
        cyc(1'b1, 1'b1, 1'b1, 8'h33, 5'b00100);
        cyc(1'b1, 1'b1, 1'b1, 8'h44, 5'b00100);
        idle(4, 1'b1, 5'b00100);
        eq = '{18'h01100, 18'h20014, 18'h02200, 18'h03300, 18'h04400};
        cmp_q("gap_burst");

        wq.delete();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 5'd0);
        cyc(1'b1, 1'b1, 1'b1, 8'h10, 5'd0);
        idle(2, 1'b1, 5'd0);
        cyc(1'b1, 1'b1, 1'b1, 8'h55, 5'b00001);
        idle(3, 1'b1, 5'b00001);
        eq = '{18'h01000, 18'h05502, 18'h10008};
        cmp_q("stat_defer");

        wq.delete();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 5'd0);
        cyc(1'b1, 1'b1, 1'b1, 8'h01, 5'd0);
        idle(70000, 1'b1, 5'd0);
        cyc(1'b1, 1'b1, 1'b1, 8'h02, 5'd0);
        idle(3, 1'b1, 5'd0);
        eq = '{18'h00100, 18'h2FFFF, 18'h21171, 18'h00200};
        cmp_q("wrap");
        chk("wrap_cnt", 32'(data_count), 32'd2);

        wq.delete();
        idle(10, 1'b1, 5'd0);
        cyc(1'b1, 1'b1, 1'b1, 8'hAA, 5'd0);
        chk("rst_pre_din", 32'(fifo_din), 32'h2000D);
        reset = 1'b1;
        @(posedge fe_clk); #1;
        chk("rst_wr", 32'(fifo_wr), 32'd0);
        chk("rst_din", 32'(fifo_din), 32'd0);
        chk("rst_cnt", 32'(data_count), 32'd0);
        idle(3, 1'b1, 5'd0);
        eq = '{18'h2000D};
        cmp_q("rst_hold");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
